// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: buffer state, buffered-entry port needs
// and the vector lane mask width.
package wb_pkg;

  localparam int WB_MASK_W = 4;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic reg_need;
    logic vec_need;
  } wb_need_t;

endpackage

// File: rtl/wb_sat_counter.sv
// Saturating event counter. It clears on rst and reads zero while rst is held.
module wb_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = rst ? '0 : r_count;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the shared scalar/vector writeback mux, with a one-entry vector holding buffer.
// Optional statistics counters are enabled by defining WB_ARB_STATS_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scalar_pipeline_we,
  input  logic [WB_MASK_W-1:0] scalar_pipeline_mask,
  input  logic                 vector_pipeline_we,
  input  logic [WB_MASK_W-1:0] vector_pipeline_mask,
  output logic                 register_wb_sel,
  output logic                 vector_wb_sel,
  output logic                 buffer_register_sel,
  output logic                 buffer_vector_sel,
  output logic                 buffer_register,
  output logic                 buffer_vector,
  output logic                 scalar_stall,
`ifdef WB_ARB_STATS_EN
  output logic                 buf_full,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     defer_cnt
`else
  output logic                 buf_full
`endif
);

  wb_state_t r_state;
  wb_need_t  r_need;

  logic w_s_r;
  logic w_s_v;
  logic w_v_r;
  logic w_v_v;
  logic w_vvalid;
  logic w_conflict;

  assign w_s_r      = scalar_pipeline_we;
  assign w_s_v      = |scalar_pipeline_mask;
  assign w_v_r      = vector_pipeline_we;
  assign w_v_v      = |vector_pipeline_mask;
  assign w_vvalid   = w_v_r | w_v_v;
  assign w_conflict = (w_v_r & w_s_r) | (w_v_v & w_s_v);

  // Reset forces every output low so the scalar side owns both ports and nothing is captured.
  always_comb begin
    register_wb_sel     = 1'b0;
    vector_wb_sel       = 1'b0;
    buffer_register_sel = 1'b0;
    buffer_vector_sel   = 1'b0;
    buffer_register     = 1'b0;
    buffer_vector       = 1'b0;
    scalar_stall        = 1'b0;
    buf_full            = 1'b0;
    if (!rst) begin
      case (r_state)
        WB_EMPTY: begin
          if (w_vvalid) begin
            if (w_conflict) begin
              buffer_register = 1'b1;
              buffer_vector   = 1'b1;
            end else begin
              register_wb_sel = w_v_r;
              vector_wb_sel   = w_v_v;
            end
          end
        end
        WB_FULL: begin
          register_wb_sel     = r_need.reg_need;
          buffer_register_sel = r_need.reg_need;
          vector_wb_sel       = r_need.vec_need;
          buffer_vector_sel   = r_need.vec_need;
          scalar_stall        = (r_need.reg_need & w_s_r) | (r_need.vec_need & w_s_v);
          buffer_register     = w_vvalid;
          buffer_vector       = w_vvalid;
          buf_full            = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The buffer drains every FULL cycle, so a new vector result can always be captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WB_EMPTY;
      r_need  <= '0;
    end else begin
      case (r_state)
        WB_EMPTY: begin
          if (w_vvalid && w_conflict) begin
            r_state         <= WB_FULL;
            r_need.reg_need <= w_v_r;
            r_need.vec_need <= w_v_v;
          end
        end
        WB_FULL: begin
          if (w_vvalid) begin
            r_need.reg_need <= w_v_r;
            r_need.vec_need <= w_v_v;
          end else begin
            r_state <= WB_EMPTY;
            r_need  <= '0;
          end
        end
        default: begin
          r_state <= WB_EMPTY;
          r_need  <= '0;
        end
      endcase
    end
  end

`ifdef WB_ARB_STATS_EN
  wb_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (scalar_stall),
    .count (stall_cnt)
  );

  wb_sat_counter #(.CNT_W(CNT_W)) u_defer_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (buffer_register | buffer_vector),
    .count (defer_cnt)
  );
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter. Outputs are packed as
// {register_wb_sel, vector_wb_sel, buffer_register_sel, buffer_vector_sel, buffer_register, buffer_vector, scalar_stall, buf_full}.
module tb_wb_arbiter;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             scalar_pipeline_we;
  logic [3:0]       scalar_pipeline_mask;
  logic             vector_pipeline_we;
  logic [3:0]       vector_pipeline_mask;
  logic             register_wb_sel;
  logic             vector_wb_sel;
  logic             buffer_register_sel;
  logic             buffer_vector_sel;
  logic             buffer_register;
  logic             buffer_vector;
  logic             scalar_stall;
  logic             buf_full;
`ifdef WB_ARB_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] defer_cnt;
`endif

  int compared;
  int mismatched;

  wb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .scalar_pipeline_we   (scalar_pipeline_we),
    .scalar_pipeline_mask (scalar_pipeline_mask),
    .vector_pipeline_we   (vector_pipeline_we),
    .vector_pipeline_mask (vector_pipeline_mask),
    .register_wb_sel      (register_wb_sel),
    .vector_wb_sel        (vector_wb_sel),
    .buffer_register_sel  (buffer_register_sel),
    .buffer_vector_sel    (buffer_vector_sel),
    .buffer_register      (buffer_register),
    .buffer_vector        (buffer_vector),
    .scalar_stall         (scalar_stall),
`ifdef WB_ARB_STATS_EN
    .buf_full             (buf_full),
    .stall_cnt            (stall_cnt),
    .defer_cnt            (defer_cnt)
`else
    .buf_full             (buf_full)
`endif
  );

  logic [7:0] obs;
  assign obs = {register_wb_sel, vector_wb_sel, buffer_register_sel, buffer_vector_sel,
                buffer_register, buffer_vector, scalar_stall, buf_full};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs just after a rising edge, then let combinational outputs settle.
  task automatic drive(input logic s_we, input logic [3:0] s_mask,
                       input logic v_we, input logic [3:0] v_mask);
    scalar_pipeline_we   = s_we;
    scalar_pipeline_mask = s_mask;
    vector_pipeline_we   = v_we;
    vector_pipeline_mask = v_mask;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'hF, 1'b1, 4'hF);
    compared++;
    if (obs !== 8'b0000_0000) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b want %b", obs, 8'b0000_0000);
    end
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 4'h0);
    compared++;
    if (obs !== 8'b0000_0000) begin
      mismatched++;
      $display("FAIL reset_idle: got %b want %b", obs, 8'b0000_0000);
    end
    $display("test_reset: obs=%b", obs);
    step();
  endtask

  task automatic test_pass_through();
    drive(1'b0, 4'hF, 1'b1, 4'h0);
    compared++;
    if (obs !== 8'b1000_0000) begin
      mismatched++;
      $display("FAIL pass_reg: got %b want %b", obs, 8'b1000_0000);
    end
    step();
    drive(1'b1, 4'h0, 1'b0, 4'h3);
    compared++;
    if (obs !== 8'b0100_0000) begin
      mismatched++;
      $display("FAIL pass_vec: got %b want %b", obs, 8'b0100_0000);
    end
    step();
    drive(1'b0, 4'h0, 1'b0, 4'h0);
    compared++;
    if (obs !== 8'b0000_0000) begin
      mismatched++;
      $display("FAIL pass_still_empty: got %b want %b", obs, 8'b0000_0000);
    end
    $display("test_pass_through: obs=%b", obs);
    step();
  endtask

  task automatic test_collision_defer();
    drive(1'b1, 4'h0, 1'b1, 4'h0);
    compared++;
    if (obs !== 8'b0000_1100) begin
      mismatched++;
      $display("FAIL defer_capture: got %b want %b", obs, 8'b0000_1100);
    end
    step();
    drive(1'b0, 4'h0, 1'b0, 4'h0);
    compared++;
    if (obs !== 8'b1010_0001) begin
      mismatched++;
      $display("FAIL defer_commit: got %b want %b", obs, 8'b1010_0001);
    end
    step();
    compared++;
    if (obs !== 8'b0000_0000) begin
      mismatched++;
      $display("FAIL defer_empty: got %b want %b", obs, 8'b0000_0000);
    end
    $display("test_collision_defer: obs=%b", obs);
  endtask

  task automatic test_drain_stall();
    drive(1'b0, 4'h1, 1'b0, 4'h2);
    compared++;
    if (obs !== 8'b0000_1100) begin
      mismatched++;
      $display("FAIL stall_capture: got %b want %b", obs, 8'b0000_1100);
    end
    step();
    drive(1'b0, 4'h3, 1'b0, 4'h0);
    compared++;
    if (obs !== 8'b0101_0011) begin
      mismatched++;
      $display("FAIL stall_drain: got %b want %b", obs, 8'b0101_0011);
    end
    step();
    compared++;
    if (obs !== 8'b0000_0000) begin
      mismatched++;
      $display("FAIL stall_released: got %b want %b", obs, 8'b0000_0000);
    end
    $display("test_drain_stall: obs=%b", obs);
    drive(1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic test_drain_refill();
    drive(1'b1, 4'h0, 1'b1, 4'h0);
    step();
    drive(1'b0, 4'h0, 1'b0, 4'h1);
    compared++;
    if (obs !== 8'b1010_1101) begin
      mismatched++;
      $display("FAIL refill_cycle: got %b want %b", obs, 8'b1010_1101);
    end
    step();
    drive(1'b0, 4'h0, 1'b0, 4'h0);
    compared++;
    if (obs !== 8'b0101_0001) begin
      mismatched++;
      $display("FAIL refill_drain: got %b want %b", obs, 8'b0101_0001);
    end
    step();
    compared++;
    if (obs !== 8'b0000_0000) begin
      mismatched++;
      $display("FAIL refill_empty: got %b want %b", obs, 8'b0000_0000);
    end
    $display("test_drain_refill: obs=%b", obs);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'h0, 1'b1, 4'h0);
    compared++;
    if (obs !== 8'b0000_1100) begin
      mismatched++;
      $display("FAIL b2b_first: got %b want %b", obs, 8'b0000_1100);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      compared++;
      if (obs !== 8'b1010_1111) begin
        mismatched++;
        $display("FAIL b2b_stall%0d: got %b want %b", i, obs, 8'b1010_1111);
      end
    end
    step();
    drive(1'b0, 4'h0, 1'b0, 4'h0);
    compared++;
    if (obs !== 8'b1010_0001) begin
      mismatched++;
      $display("FAIL b2b_last_drain: got %b want %b", obs, 8'b1010_0001);
    end
    step();
    $display("test_back_to_back: obs=%b", obs);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'hF, 1'b1, 4'hF);
    step();
    drive(1'b1, 4'hF, 1'b0, 4'h0);
    rst = 1'b1;
    #1;
    compared++;
    if (obs !== 8'b0000_0000) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: got %b want %b", obs, 8'b0000_0000);
    end
    step();
    rst = 1'b0;
    #1;
    compared++;
    if (obs !== 8'b0000_0000) begin
      mismatched++;
      $display("FAIL rst_mid_no_drain: got %b want %b", obs, 8'b0000_0000);
    end
    $display("test_reset_mid: obs=%b", obs);
    drive(1'b0, 4'h0, 1'b0, 4'h0);
    step();
  endtask

`ifdef WB_ARB_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 4'h0);
    compared++;
    if ({stall_cnt, defer_cnt} !== 4'b0000) begin
      mismatched++;
      $display("FAIL stats_reset: got stall=%0d defer=%0d want 0/0", stall_cnt, defer_cnt);
    end
    step();
    rst = 1'b0;
    drive(1'b1, 4'h0, 1'b1, 4'h0);
    step();
    compared++;
    if ({stall_cnt, defer_cnt} !== {2'd0, 2'd1}) begin
      mismatched++;
      $display("FAIL stats_first: got stall=%0d defer=%0d want 0/1", stall_cnt, defer_cnt);
    end
    step();
    compared++;
    if ({stall_cnt, defer_cnt} !== {2'd1, 2'd2}) begin
      mismatched++;
      $display("FAIL stats_second: got stall=%0d defer=%0d want 1/2", stall_cnt, defer_cnt);
    end
    for (int i = 0; i < 4; i++) step();
    drive(1'b0, 4'h0, 1'b0, 4'h0);
    step();
    compared++;
    if ({stall_cnt, defer_cnt} !== {2'd3, 2'd3}) begin
      mismatched++;
      $display("FAIL stats_saturated: got stall=%0d defer=%0d want 3/3", stall_cnt, defer_cnt);
    end
    $display("test_stats: stall=%0d defer=%0d", stall_cnt, defer_cnt);
    rst = 1'b1;
    #1;
    compared++;
    if ({stall_cnt, defer_cnt} !== 4'b0000) begin
      mismatched++;
      $display("FAIL stats_clear: got stall=%0d defer=%0d want 0/0", stall_cnt, defer_cnt);
    end
    step();
    rst = 1'b0;
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    scalar_pipeline_we   = 1'b0;
    scalar_pipeline_mask = 4'h0;
    vector_pipeline_we   = 1'b0;
    vector_pipeline_mask = 4'h0;
    step();
    test_reset();
    test_pass_through();
    test_collision_defer();
    test_drain_stall();
    test_drain_refill();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
